// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared constants, FSM state type and byte transform for the UART echo buffer
//
// Purpose : mode encodings, CR/LF characters, Tx FSM state enum and the
//           combinational case transform applied when a byte is loaded for Tx.
// Ports   : none (package).
package uart_echo_pkg;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_TOGGLE = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_LOWER  = 2'd3;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT
   } state_t;

   // Bit 5 is the ASCII case bit; only letters are touched, so CR/LF and all
   // other non-letters pass through unchanged in every mode.
   function automatic logic [7:0] transform(input logic [7:0] b, input logic [1:0] mode);
      logic       is_upper;
      logic       is_lower;
      logic [7:0] r;
      is_upper = (b >= 8'h41) && (b <= 8'h5A);
      is_lower = (b >= 8'h61) && (b <= 8'h7A);
      r        = b;
      case (mode)
         MODE_TOGGLE: if (is_upper || is_lower) r = b ^ 8'h20;
         MODE_UPPER:  if (is_lower)             r = b ^ 8'h20;
         MODE_LOWER:  if (is_upper)             r = b ^ 8'h20;
         default:                               r = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - parametrised synchronous byte FIFO with level counter
//
// Purpose : DEPTH-entry byte queue; full/empty are derived from the level
//           counter, pointers wrap modulo DEPTH.
// Ports   : clk    in   clock, rising edge
//           rst    in   asynchronous active-high reset, empties the FIFO
//           push   in   write din (ignored when full)
//           din    in   byte to write
//           pop    in   discard head (ignored when empty)
//           head   out  oldest stored byte
//           level  out  occupancy, 0..DEPTH
//           full   out  level == DEPTH
//           empty  out  level == 0
module byte_fifo #(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [7:0]        din,
   input  logic              pop,
   output logic [7:0]        head,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == (ADDR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - buffered UART echo path with case transform and CR->CRLF expansion
//
// Purpose : queues received bytes, transforms them per ipMode at load time and
//           hands them to the UART transmitter via the Send/Busy handshake.
// Ports   : ipClk        in   clock, rising edge
//           ipReset      in   asynchronous active-high reset
//           ipRxData     in   received byte
//           ipRxValid    in   one-cycle strobe for ipRxData
//           ipMode       in   transform mode, sampled on each Tx load
//           opTxData     out  byte to transmitter, stable while in SEND
//           opTxSend     out  send request
//           ipTxBusy     in   transmitter busy
//           opLevel      out  FIFO occupancy (a CR awaiting its LF still counts)
//           opOverflow   out  sticky dropped-byte flag
//           opDropCount  out  saturating dropped-byte count
module uart_echo_buffer #(
   parameter  int DEPTH       = 16,
   parameter  int CRLF_EXPAND = 1,
   parameter  int DROP_W      = 8,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic              ipClk,
   input  logic              ipReset,
   input  logic [7:0]        ipRxData,
   input  logic              ipRxValid,
   input  logic [1:0]        ipMode,
   output logic [7:0]        opTxData,
   output logic              opTxSend,
   input  logic              ipTxBusy,
   output logic [ADDR_W:0]   opLevel,
   output logic              opOverflow,
   output logic [DROP_W-1:0] opDropCount
);

   import uart_echo_pkg::*;

   state_t     state;
   logic       lf_pending;
   logic [7:0] head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       head_is_cr;
   logic       load_lf;
   logic       load_head;
   logic       pop;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (ipClk),
      .rst   (ipReset),
      .push  (ipRxValid && !fifo_full),
      .din   (ipRxData),
      .pop   (pop),
      .head  (head),
      .level (opLevel),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_is_cr = (CRLF_EXPAND != 0) && (head == CHAR_CR);
   assign load_lf    = (state == ST_IDLE) && lf_pending;
   assign load_head  = (state == ST_IDLE) && !lf_pending && !fifo_empty && !ipTxBusy;
   // A CR being expanded stays in the FIFO until its LF is loaded.
   assign pop        = load_lf || (load_head && !head_is_cr);

   // Full is the registered level, so a push while full is dropped even if
   // a pop frees a slot on the same edge.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         opOverflow  <= 1'b0;
         opDropCount <= '0;
      end else if (ipRxValid && fifo_full) begin
         opOverflow <= 1'b1;
         if (opDropCount != '1) opDropCount <= opDropCount + 1'b1;
      end
   end

   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         state      <= ST_IDLE;
         opTxData   <= '0;
         opTxSend   <= 1'b0;
         lf_pending <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_lf) begin
                  opTxData   <= CHAR_LF;
                  lf_pending <= 1'b0;
                  opTxSend   <= 1'b1;
                  state      <= ST_SEND;
               end else if (load_head) begin
                  opTxData   <= transform(head, ipMode);
                  lf_pending <= head_is_cr;
                  opTxSend   <= 1'b1;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (ipTxBusy) begin
                  opTxSend <= 1'b0;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!ipTxBusy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
